// File: rtl/sprite_motion_if.sv
// Signal bundle between the frame-rate scheduler and its driver: raw vsync,
// button pulses in; frame/step strobes and status out.
interface sprite_motion_if #(
  parameter int unsigned FCNT_W = 16
);
  logic              vs;
  logic              start_btn;
  logic              pause_btn;
  logic              center_btn;
  logic              speed_up;
  logic              speed_down;
  logic              vs_negedge;
  logic              step;
  logic              loc_rst;
  logic [1:0]        state;
  logic [2:0]        speed;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output vs, start_btn, pause_btn, center_btn, speed_up, speed_down,
    input  vs_negedge, step, loc_rst, state, speed, frame_cnt
  );

  modport slave (
    input  vs, start_btn, pause_btn, center_btn, speed_up, speed_down,
    output vs_negedge, step, loc_rst, state, speed, frame_cnt
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-rate scheduler: turns raw vsync into frame ticks and decides on which
// frames the sprite position block steps, with start/pause/recenter and speed.
module sprite_motion_ctrl #(
  parameter logic [2:0]  DEFAULT_SPEED = 3'd5,
  parameter int unsigned FCNT_W        = 16
) (
  input  logic           clk_25MHz,
  input  logic           rst,
  sprite_motion_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CENTER = 2'b01,
    RUN    = 2'b10,
    PAUSE  = 2'b11
  } state_e;

  localparam logic [FCNT_W-1:0] FC_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              vs_s1_q, vs_s2_q, vs_s3_q;
  logic              fe;
  logic [2:0]        speed_q, speed_d;
  logic [2:0]        div_q, div_d;
  logic              step_q, step_d;
  logic              loc_rst_q, loc_rst_d;
  logic              vs_negedge_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              spd_en;

  assign fe = vs_s3_q & ~vs_s2_q;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    div_d   = div_q;
    step_d  = 1'b0;
    spd_en  = (state_q == RUN) || (state_q == PAUSE);

    if (spd_en && bus.speed_up && !bus.speed_down && (speed_q != 3'd7)) begin
      speed_d = speed_q + 3'd1;
    end else if (spd_en && bus.speed_down && !bus.speed_up && (speed_q != 3'd0)) begin
      speed_d = speed_q - 3'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start_btn) state_d = CENTER;
      end
      CENTER: begin
        if (fe) begin
          step_d  = 1'b1;
          div_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A state change on the frame edge suppresses that frame's step.
        if (bus.center_btn) begin
          state_d = CENTER;
        end else if (bus.pause_btn) begin
          state_d = PAUSE;
        end else if (fe) begin
          if (div_q == (3'd7 - speed_q)) begin
            step_d = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + 3'd1;
          end
        end
      end
      PAUSE: begin
        if (bus.center_btn) begin
          state_d = CENTER;
        end else if (bus.pause_btn || bus.start_btn) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (speed_d != speed_q) div_d = '0;

    // Held through the CENTER step cycle so the position block sees
    // step and location reset together, then released.
    loc_rst_d = (state_d == IDLE) || (state_d == CENTER) || (state_q == CENTER);
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      speed_q      <= DEFAULT_SPEED;
      div_q        <= '0;
      step_q       <= 1'b0;
      vs_negedge_q <= 1'b0;
      loc_rst_q    <= 1'b1;
      frame_cnt_q  <= '0;
      vs_s1_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      vs_s3_q      <= 1'b1;
    end else begin
      vs_s1_q      <= bus.vs;
      vs_s2_q      <= vs_s1_q;
      vs_s3_q      <= vs_s2_q;
      state_q      <= state_d;
      speed_q      <= speed_d;
      div_q        <= div_d;
      step_q       <= step_d;
      vs_negedge_q <= fe;
      loc_rst_q    <= loc_rst_d;
      if (fe) frame_cnt_q <= frame_cnt_q + FC_ONE;
    end
  end

  assign bus.vs_negedge = vs_negedge_q;
  assign bus.step       = step_q;
  assign bus.loc_rst    = loc_rst_q;
  assign bus.state      = state_q;
  assign bus.speed      = speed_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with a 4-bit frame counter; vsync
// frames are 20 cycles with a 3-cycle low pulse.
module tb_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   step_cnt = 0;
  int   vsn_cnt = 0;
  logic step_locrst = 1'b0;

  sprite_motion_if #(.FCNT_W(4)) bus ();

  sprite_motion_ctrl #(.DEFAULT_SPEED(3'd5), .FCNT_W(4)) dut (
    .clk_25MHz(clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.step === 1'b1) begin
      step_cnt++;
      step_locrst = bus.loc_rst;
    end
    if (bus.vs_negedge === 1'b1) vsn_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic frame_n(input int n);
    for (int f = 0; f < n; f++) begin
      bus.vs = 1'b0;
      repeat (3) tick();
      bus.vs = 1'b1;
      repeat (17) tick();
    end
  endtask

  task automatic pulse(input logic st, input logic pa, input logic ce, input logic up, input logic dn);
    bus.start_btn = st; bus.pause_btn = pa; bus.center_btn = ce;
    bus.speed_up = up; bus.speed_down = dn;
    tick();
    bus.start_btn = 1'b0; bus.pause_btn = 1'b0; bus.center_btn = 1'b0;
    bus.speed_up = 1'b0; bus.speed_down = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    checks++; if (bus.speed !== 3'd5) begin errors++; $display("FAIL reset_speed got %0d exp 5", bus.speed); end
    checks++; if (bus.loc_rst !== 1'b1) begin errors++; $display("FAIL reset_loc_rst got %0b exp 1", bus.loc_rst); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step got %0b exp 0", bus.step); end
    checks++; if (bus.vs_negedge !== 1'b0) begin errors++; $display("FAIL reset_vs_negedge got %0b exp 0", bus.vs_negedge); end
    checks++; if (bus.frame_cnt !== 4'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", bus.frame_cnt); end
    rst = 1'b0;
    tick();
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL post_reset_state got %0d exp 0", bus.state); end
  endtask

  task automatic test_idle();
    int s0, v0;
    s0 = step_cnt; v0 = vsn_cnt;
    bus.vs = 1'b0;
    tick(); tick();
    checks++; if (bus.vs_negedge !== 1'b0) begin errors++; $display("FAIL vsn_early got %0b exp 0", bus.vs_negedge); end
    tick();
    checks++; if (bus.vs_negedge !== 1'b1) begin errors++; $display("FAIL vsn_latency got %0b exp 1", bus.vs_negedge); end
    bus.vs = 1'b1;
    tick();
    checks++; if (bus.vs_negedge !== 1'b0) begin errors++; $display("FAIL vsn_width got %0b exp 0", bus.vs_negedge); end
    repeat (16) tick();
    frame_n(2);
    checks++; if (bus.frame_cnt !== 4'd3) begin errors++; $display("FAIL idle_frame_cnt got %0d exp 3", bus.frame_cnt); end
    checks++; if (vsn_cnt - v0 !== 3) begin errors++; $display("FAIL idle_vsn_count got %0d exp 3", vsn_cnt - v0); end
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL idle_no_step got %0d exp 0", step_cnt - s0); end
    pulse(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL idle_ignore_state got %0d exp 0", bus.state); end
    checks++; if (bus.speed !== 3'd5) begin errors++; $display("FAIL idle_ignore_speed got %0d exp 5", bus.speed); end
    checks++; if (bus.loc_rst !== 1'b1) begin errors++; $display("FAIL idle_loc_rst got %0b exp 1", bus.loc_rst); end
  endtask

  task automatic test_start();
    int s0;
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL start_state got %0d exp 1", bus.state); end
    checks++; if (bus.loc_rst !== 1'b1) begin errors++; $display("FAIL center_loc_rst got %0b exp 1", bus.loc_rst); end
    s0 = step_cnt;
    frame_n(1);
    checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL center_step got %0d exp 1", step_cnt - s0); end
    checks++; if (step_locrst !== 1'b1) begin errors++; $display("FAIL center_step_loc_rst got %0b exp 1", step_locrst); end
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL run_state got %0d exp 2", bus.state); end
    checks++; if (bus.loc_rst !== 1'b0) begin errors++; $display("FAIL run_loc_rst got %0b exp 0", bus.loc_rst); end
    s0 = step_cnt;
    frame_n(2);
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL run_first_gap got %0d exp 0", step_cnt - s0); end
    frame_n(1);
    checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL run_first_step got %0d exp 1", step_cnt - s0); end
    checks++; if (step_locrst !== 1'b0) begin errors++; $display("FAIL run_step_loc_rst got %0b exp 0", step_locrst); end
    frame_n(3);
    checks++; if (step_cnt - s0 !== 2) begin errors++; $display("FAIL run_period3 got %0d exp 2", step_cnt - s0); end
  endtask

  task automatic test_speed();
    int s0;
    repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.speed !== 3'd7) begin errors++; $display("FAIL speed_sat_hi got %0d exp 7", bus.speed); end
    s0 = step_cnt;
    frame_n(4);
    checks++; if (step_cnt - s0 !== 4) begin errors++; $display("FAIL speed7_steps got %0d exp 4", step_cnt - s0); end
    repeat (8) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.speed !== 3'd0) begin errors++; $display("FAIL speed_sat_lo got %0d exp 0", bus.speed); end
    s0 = step_cnt;
    frame_n(7);
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL speed0_gap got %0d exp 0", step_cnt - s0); end
    frame_n(1);
    checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL speed0_step got %0d exp 1", step_cnt - s0); end
    repeat (5) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.speed !== 3'd5) begin errors++; $display("FAIL speed_back5 got %0d exp 5", bus.speed); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.speed !== 3'd5) begin errors++; $display("FAIL speed_updown got %0d exp 5", bus.speed); end
  endtask

  task automatic test_pause();
    int s0;
    logic [3:0] fc0, fc_exp;
    s0 = step_cnt;
    frame_n(1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL pause_state got %0d exp 3", bus.state); end
    checks++; if (bus.loc_rst !== 1'b0) begin errors++; $display("FAIL pause_loc_rst got %0b exp 0", bus.loc_rst); end
    fc0 = bus.frame_cnt;
    frame_n(10);
    fc_exp = fc0 + 4'd10;
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL pause_no_step got %0d exp 0", step_cnt - s0); end
    checks++; if (bus.frame_cnt !== fc_exp) begin errors++; $display("FAIL pause_frame_cnt got %0d exp %0d", bus.frame_cnt, fc_exp); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL resume_state got %0d exp 2", bus.state); end
    frame_n(1);
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL resume_held_gap got %0d exp 0", step_cnt - s0); end
    frame_n(1);
    checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL resume_held_step got %0d exp 1", step_cnt - s0); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL start_resume_state got %0d exp 2", bus.state); end
  endtask

  task automatic test_center_fe();
    int s0;
    s0 = step_cnt;
    bus.vs = 1'b0;
    tick(); tick();
    bus.center_btn = 1'b1;
    tick();
    bus.center_btn = 1'b0;
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL center_fe_state got %0d exp 1", bus.state); end
    checks++; if (bus.vs_negedge !== 1'b1) begin errors++; $display("FAIL center_fe_vsn got %0b exp 1", bus.vs_negedge); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL center_fe_step got %0b exp 0", bus.step); end
    bus.vs = 1'b1;
    repeat (17) tick();
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL center_fe_nostep got %0d exp 0", step_cnt - s0); end
    frame_n(1);
    checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL recenter_step got %0d exp 1", step_cnt - s0); end
    checks++; if (step_locrst !== 1'b1) begin errors++; $display("FAIL recenter_loc_rst got %0b exp 1", step_locrst); end
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL recenter_run got %0d exp 2", bus.state); end
  endtask

  task automatic test_btn_with_fe();
    int s0;
    frame_n(2);
    s0 = step_cnt;
    bus.vs = 1'b0;
    tick(); tick();
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL btn_fe_step got %0b exp 1", bus.step); end
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL btn_fe_state got %0d exp 2", bus.state); end
    bus.vs = 1'b1;
    repeat (17) tick();
    checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL btn_fe_count got %0d exp 1", step_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    int s0;
    frame_n(2);
    s0 = step_cnt;
    bus.vs = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rst_mid_state got %0d exp 0", bus.state); end
    checks++; if (bus.loc_rst !== 1'b1) begin errors++; $display("FAIL rst_mid_loc_rst got %0b exp 1", bus.loc_rst); end
    checks++; if (bus.frame_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_frame_cnt got %0d exp 0", bus.frame_cnt); end
    checks++; if (bus.speed !== 3'd5) begin errors++; $display("FAIL rst_mid_speed got %0d exp 5", bus.speed); end
    tick();
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL rst_mid_step got %0b exp 0", bus.step); end
    bus.vs = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL rst_mid_lost_step got %0d exp 0", step_cnt - s0); end
    checks++; if (bus.frame_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_no_fe got %0d exp 0", bus.frame_cnt); end
  endtask

  task automatic test_wrap();
    int v0;
    v0 = vsn_cnt;
    frame_n(15);
    checks++; if (bus.frame_cnt !== 4'd15) begin errors++; $display("FAIL wrap_allones got %0d exp 15", bus.frame_cnt); end
    frame_n(1);
    checks++; if (bus.frame_cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", bus.frame_cnt); end
    checks++; if (vsn_cnt - v0 !== 16) begin errors++; $display("FAIL wrap_vsn_count got %0d exp 16", vsn_cnt - v0); end
  endtask

  initial begin
    bus.vs = 1'b1;
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    bus.center_btn = 1'b0;
    bus.speed_up = 1'b0;
    bus.speed_down = 1'b0;
    test_reset();
    test_idle();
    test_start();
    test_speed();
    test_pause();
    test_center_fe();
    test_btn_with_fe();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
